// File: rtl/program_loader.sv
// Byte-stream loader for the MiniAlu instruction RAM: length header, 4-byte words, core held in reset until done.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in a CHECK state.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 28
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               iStart,
    input  logic [7:0]         iData,
    input  logic               iValid,
    output logic               oReady,
    output logic               oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddress,
    output logic [INSTR_W-1:0] oWriteData,
    output logic               oCpuReset,
    output logic               oLoaded,
    output logic               oError,
    output logic [2:0]         oState
);
    // Handshake: a byte moves on a rising edge where iValid & oReady; oReady depends only on state.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t TAIL_STATE = S_CHECK;
`else
    localparam state_t TAIL_STATE = S_DONE;
`endif
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state, nextState;
    logic [1:0]        byteIdx;
    logic [7:0]        lenLo;
    logic [15:0]       lenWords;
    logic [15:0]       wordCount;
    logic [ADDR_W-1:0] writeAddr;
    logic [23:0]       wordBuf;
    logic              accept, startLoad, lastWord, badTop, wordDone;
    logic [15:0]       lenFull;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    assign oReady    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHECK);
    assign accept    = oReady & iValid;
    assign startLoad = iStart && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign lenFull   = {iData, lenLo};
    assign lastWord  = (wordCount == lenWords - 16'd1);
    assign badTop    = |iData[7:INSTR_W-24];
    assign wordDone  = (state == S_DATA) && accept && (byteIdx == 2'd3) && !badTop;

    // The DONE state is entered on the last write edge; release waits until the strobe is gone.
    assign oLoaded   = (state == S_DONE) && !oWriteEnable;
    assign oCpuReset = !oLoaded;
    assign oError    = (state == S_ERROR);
    assign oState    = state;

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (iStart) nextState = S_LEN_LO;
            S_LEN_LO: if (accept) nextState = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, lenFull} > MAX_WORDS) nextState = S_ERROR;
                    else if (lenFull == 16'd0)       nextState = TAIL_STATE;
                    else                             nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byteIdx == 2'd3) begin
                    if (badTop)        nextState = S_ERROR;
                    else if (lastWord) nextState = TAIL_STATE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (accept) nextState = (iData == checksum) ? S_DONE : S_ERROR;
`endif
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_IDLE;
            byteIdx       <= 2'd0;
            lenLo         <= 8'd0;
            lenWords      <= 16'd0;
            wordCount     <= 16'd0;
            writeAddr     <= '0;
            wordBuf       <= 24'd0;
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
        end else begin
            state        <= nextState;
            oWriteEnable <= 1'b0;
            if (startLoad) begin
                writeAddr <= '0;
                byteIdx   <= 2'd0;
                wordCount <= 16'd0;
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: lenLo    <= iData;
                    S_LEN_HI: lenWords <= lenFull;
                    S_DATA: begin
                        byteIdx <= byteIdx + 2'd1;
                        case (byteIdx)
                            2'd0:    wordBuf[7:0]   <= iData;
                            2'd1:    wordBuf[15:8]  <= iData;
                            2'd2:    wordBuf[23:16] <= iData;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            if (wordDone) begin
                oWriteEnable  <= 1'b1;
                oWriteAddress <= writeAddr;
                oWriteData    <= {iData[INSTR_W-25:0], wordBuf};
                writeAddr     <= writeAddr + ADDR_W'(1);
                wordCount     <= wordCount + 16'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Covers both length bytes and every data byte, but not the checksum byte itself.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                        checksum <= 8'd0;
        else if (startLoad)                  checksum <= 8'd0;
        else if (accept && state != S_CHECK) checksum <= checksum ^ iData;
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: streams, stalls, aborts, async reset and the optional checksum.
module tb_program_loader;
    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        iStart;
    logic [7:0]  iData;
    logic        iValid;
    logic        oReady;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [27:0] oWriteData;
    logic        oCpuReset;
    logic        oLoaded;
    logic        oError;
    logic [2:0]  oState;

    int          checks = 0;
    int          failures = 0;
    logic [35:0] expQ[$];
    logic [7:0]  txQ[$];
    logic [35:0] expWord;

    program_loader #(.ADDR_W(8), .INSTR_W(28)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .iStart(iStart), .iData(iData), .iValid(iValid),
        .oReady(oReady), .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
        .oWriteData(oWriteData), .oCpuReset(oCpuReset), .oLoaded(oLoaded), .oError(oError),
        .oState(oState)
    );

    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulseStart();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int   t;
        logic ok;
        t = 0;
        ok = 1'b0;
        iData = b;
        iValid = 1'b1;
        while (!ok && t < 20) begin
            @(negedge Clock);
            ok = oReady;
            @(posedge Clock);
            #1;
            t++;
        end
        if (!ok) checkValue("readyTimeout", 32'd0, 32'd1);
    endtask

    task automatic streamLoad(input bit toggle);
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 0; i < txQ.size(); i++) begin
            sendByte(txQ[i]);
            sum ^= txQ[i];
            if (i >= 2 && ((i - 2) % 4) == 3) begin
                checkValue("strobeAfterByte3", {31'd0, oWriteEnable}, 32'd1);
                if (i == txQ.size() - 1) checkValue("loadedLowDuringStrobe", {31'd0, oLoaded}, 32'd0);
            end
            if (toggle) begin
                iValid = 1'b0;
                tick();
            end
        end
`ifdef LOADER_CHECKSUM_EN
        sendByte(sum);
        iValid = 1'b0;
        checkValue("loadedAfterCheck", {31'd0, oLoaded}, 32'd1);
`else
        iValid = 1'b0;
        if (!toggle) tick();
        checkValue("loadedAfterLast", {31'd0, oLoaded}, 32'd1);
`endif
        checkValue("cpuReleased", {31'd0, oCpuReset}, 32'd0);
        checkValue("readyLowDone", {31'd0, oReady}, 32'd0);
    endtask

    always @(negedge Clock) begin
        if (Reset_n === 1'b1 && oWriteEnable === 1'b1) begin
            if (expQ.size() == 0) begin
                checkValue("unexpectedWrite", 32'd1, 32'd0);
            end else begin
                expWord = expQ.pop_front();
                checkValue("writeAddr", {24'd0, oWriteAddress}, {24'd0, expWord[35:28]});
                checkValue("writeData", {4'd0, oWriteData}, {4'd0, expWord[27:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        iStart  = 1'b0;
        iData   = 8'd0;
        iValid  = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checkValue("rstCpuReset", {31'd0, oCpuReset}, 32'd1);
        checkValue("rstReady", {31'd0, oReady}, 32'd0);
        checkValue("rstLoaded", {31'd0, oLoaded}, 32'd0);
        checkValue("rstError", {31'd0, oError}, 32'd0);
        checkValue("rstWe", {31'd0, oWriteEnable}, 32'd0);
        checkValue("rstState", {29'd0, oState}, 32'd0);
        Reset_n = 1'b1;
        tick();
        checkValue("idleReady", {31'd0, oReady}, 32'd0);

        // Two words, continuous stream
        pulseStart();
        checkValue("lenLoReady", {31'd0, oReady}, 32'd1);
        checkValue("cpuHeldLoading", {31'd0, oCpuReset}, 32'd1);
        expQ.push_back({8'd0, 28'h4050001});
        expQ.push_back({8'd1, 28'h0010203});
        txQ = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        streamLoad(1'b0);

        // Same stream with iValid toggling every cycle
        pulseStart();
        checkValue("restartCpuHeld", {31'd0, oCpuReset}, 32'd1);
        expQ.push_back({8'd0, 28'h4050001});
        expQ.push_back({8'd1, 28'h0010203});
        streamLoad(1'b1);

`ifndef LOADER_CHECKSUM_EN
        // Zero-length program finishes right after the length header
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h00);
        iValid = 1'b0;
        checkValue("zeroLenLoaded", {31'd0, oLoaded}, 32'd1);
        checkValue("zeroLenCpu", {31'd0, oCpuReset}, 32'd0);
        checkValue("zeroLenNoWe", {31'd0, oWriteEnable}, 32'd0);
`endif

        // Nonzero upper nibble in byte3 aborts without a write
        pulseStart();
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h1A);
        iValid = 1'b0;
        checkValue("badTopError", {31'd0, oError}, 32'd1);
        checkValue("badTopCpu", {31'd0, oCpuReset}, 32'd1);
        checkValue("badTopNoWe", {31'd0, oWriteEnable}, 32'd0);
        checkValue("badTopReady", {31'd0, oReady}, 32'd0);
        tick();
        checkValue("badTopStillNoWe", {31'd0, oWriteEnable}, 32'd0);

        // Restart after error begins again at address 0
        pulseStart();
        checkValue("errorCleared", {31'd0, oError}, 32'd0);
        expQ.push_back({8'd0, 28'hD0C0B0A});
        txQ = '{8'h01, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        streamLoad(1'b0);

        // Length 257 exceeds the memory
        pulseStart();
        sendByte(8'h01);
        sendByte(8'h01);
        iValid = 1'b0;
        checkValue("tooLongError", {31'd0, oError}, 32'd1);

        // Length 256 is accepted; reset in the middle of the second word
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h01);
        checkValue("maxLenNoError", {31'd0, oError}, 32'd0);
        checkValue("maxLenData", {29'd0, oState}, 32'd3);
        expQ.push_back({8'd0, 28'h8070605});
        sendByte(8'h05);
        sendByte(8'h06);
        sendByte(8'h07);
        sendByte(8'h08);
        checkValue("maxLenStrobe", {31'd0, oWriteEnable}, 32'd1);
        sendByte(8'hAA);
        sendByte(8'hBB);
        iValid = 1'b0;
        Reset_n = 1'b0;
        #1;
        checkValue("midRstState", {29'd0, oState}, 32'd0);
        checkValue("midRstCpu", {31'd0, oCpuReset}, 32'd1);
        checkValue("midRstReady", {31'd0, oReady}, 32'd0);
        checkValue("midRstLoaded", {31'd0, oLoaded}, 32'd0);
        checkValue("midRstAddr", {24'd0, oWriteAddress}, 32'd0);
        checkValue("midRstData", {4'd0, oWriteData}, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();

`ifdef LOADER_CHECKSUM_EN
        // Good checksum 0x05 releases the core
        pulseStart();
        expQ.push_back({8'd0, 28'h4332211});
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h04);
        checkValue("ckStrobe", {31'd0, oWriteEnable}, 32'd1);
        sendByte(8'h05);
        iValid = 1'b0;
        checkValue("ckGoodLoaded", {31'd0, oLoaded}, 32'd1);
        checkValue("ckGoodCpu", {31'd0, oCpuReset}, 32'd0);

        // Bad checksum 0x06 aborts with the core held
        pulseStart();
        expQ.push_back({8'd0, 28'h4332211});
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h04);
        sendByte(8'h06);
        iValid = 1'b0;
        checkValue("ckBadError", {31'd0, oError}, 32'd1);
        checkValue("ckBadCpu", {31'd0, oCpuReset}, 32'd1);
`endif

        repeat (2) tick();
        checkValue("queueEmpty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
